// File: rtl/matrix_uart_seq_pkg.sv
// Shared types and constants for the UART-to-matrix-engine sequencer.
package matrix_seq_pkg;

  localparam int BYTE_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [1:0] {
    COLLECT,
    START,
    WAIT,
    SEND
  } seq_state_e;

  // Bit offset of transmit byte n inside the flattened result vector (LSB of each result first).
  function automatic int res_byte_lsb(int byte_idx);
    return (byte_idx / 2) * RES_W + (byte_idx % 2) * BYTE_W;
  endfunction

endpackage

// File: rtl/matrix_uart_seq_if.sv
// UART byte, engine handshake and status signals of the sequencer, bundled as one interface.
interface matrix_uart_seq_if #(
  parameter int N_ELEM = 4
);
  import matrix_seq_pkg::*;

  logic                       rx_valid;
  logic [BYTE_W-1:0]          rx_data;
  logic                       tx_valid;
  logic [BYTE_W-1:0]          tx_data;
  logic                       tx_ready;
  logic                       eng_start;
  logic [BYTE_W*N_ELEM-1:0]   eng_op;
  logic                       eng_done;
  logic [RES_W*N_ELEM-1:0]    eng_result;
  logic [2*RES_W-1:0]         gpio_result;
  logic                       busy;
  logic                       err_overrun;
  logic                       err_timeout;

  modport slave (
    input  rx_valid, rx_data, tx_ready, eng_done, eng_result,
    output tx_valid, tx_data, eng_start, eng_op, gpio_result, busy, err_overrun, err_timeout
  );

  modport master (
    output rx_valid, rx_data, tx_ready, eng_done, eng_result,
    input  tx_valid, tx_data, eng_start, eng_op, gpio_result, busy, err_overrun, err_timeout
  );

endinterface

// File: rtl/matrix_uart_seq_serializer.sv
// Holds the latched engine results and offers them byte by byte on a valid/ready port.
module result_tx_serializer
  import matrix_seq_pkg::*;
#(
  parameter int N_ELEM = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_i,
  input  logic [RES_W*N_ELEM-1:0]  results_i,
  input  logic                     tx_ready_i,
  output logic                     tx_valid_o,
  output logic [BYTE_W-1:0]        tx_data_o,
  output logic                     last_accepted_o
);

  localparam int N_BYTES = 2 * N_ELEM;
  localparam int PTR_W   = $clog2(N_BYTES);

  logic [RES_W*N_ELEM-1:0] res_buf_q, res_buf_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    valid_q, valid_d;
  logic [BYTE_W-1:0]       res_bytes [N_BYTES];
  logic                    accept;

  for (genvar g = 0; g < N_BYTES; g++) begin : g_byte
    assign res_bytes[g] = res_buf_q[res_byte_lsb(g) +: BYTE_W];
  end

  assign accept          = valid_q && tx_ready_i;
  assign last_accepted_o = accept && (ptr_q == PTR_W'(N_BYTES - 1));
  assign tx_valid_o      = valid_q;
  assign tx_data_o       = res_bytes[ptr_q];

  always_comb begin
    res_buf_d = res_buf_q;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    if (load_i) begin
      res_buf_d = results_i;
      ptr_d     = '0;
      valid_d   = 1'b1;
    end else if (accept) begin
      if (last_accepted_o) begin
        ptr_d   = '0;
        valid_d = 1'b0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_buf_q <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      res_buf_q <= res_buf_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: rtl/matrix_uart_seq.sv
// Collects operand bytes from the UART, runs the 2x2 matrix engine and streams results back.
// state   | meaning
// COLLECT | gathering N_ELEM operand bytes from rx
// START   | one-cycle eng_start pulse, timeout counter loaded
// WAIT    | waiting for eng_done while the timeout counter runs down
// SEND    | serializer streaming results to tx
module matrix_uart_seq
  import matrix_seq_pkg::*;
#(
  parameter int N_ELEM  = 4,
  parameter int TIMEOUT = 1024
) (
  input logic              clock,
  input logic              reset,
  matrix_uart_seq_if.slave bus
);

  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  seq_state_e               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [BYTE_W-1:0]        op_q [N_ELEM];
  logic [BYTE_W-1:0]        op_d [N_ELEM];
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [2*RES_W-1:0]       gpio_q, gpio_d;
  logic                     ovr_q, ovr_d;
  logic                     tmo_q, tmo_d;
  logic                     load;
  logic                     last_accepted;
  logic [BYTE_W*N_ELEM-1:0] op_flat;

  for (genvar g = 0; g < N_ELEM; g++) begin : g_op
    assign op_flat[g*BYTE_W +: BYTE_W] = op_q[g];
  end

  result_tx_serializer #(.N_ELEM(N_ELEM)) u_ser (
    .clock          (clock),
    .reset          (reset),
    .load_i         (load),
    .results_i      (bus.eng_result),
    .tx_ready_i     (bus.tx_ready),
    .tx_valid_o     (bus.tx_valid),
    .tx_data_o      (bus.tx_data),
    .last_accepted_o(last_accepted)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    gpio_d  = gpio_q;
    ovr_d   = ovr_q;
    tmo_d   = tmo_q;
    load    = 1'b0;
    if (bus.rx_valid && (state_q != COLLECT)) ovr_d = 1'b1;
    case (state_q)
      COLLECT: begin
        if (bus.rx_valid) begin
          op_d[idx_q] = bus.rx_data;
          if (idx_q == IDX_W'(N_ELEM - 1)) begin
            idx_d   = '0;
            state_d = START;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      START: begin
        cnt_d   = CNT_W'(TIMEOUT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // done takes priority over a counter that has just reached zero
        if (bus.eng_done) begin
          load    = 1'b1;
          gpio_d  = bus.eng_result[2*RES_W-1:0];
          state_d = SEND;
        end else if (cnt_q == '0) begin
          tmo_d   = 1'b1;
          state_d = COLLECT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SEND: begin
        if (last_accepted) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      op_q    <= '{default: '0};
      cnt_q   <= '0;
      gpio_q  <= '0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      gpio_q  <= gpio_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.eng_start   = (state_q == START);
  assign bus.busy        = (state_q != COLLECT);
  assign bus.eng_op      = op_flat;
  assign bus.gpio_result = gpio_q;
  assign bus.err_overrun = ovr_q;
  assign bus.err_timeout = tmo_q;

endmodule

// File: tb/tb_matrix_uart_seq.sv
// Directed bench for matrix_uart_seq: engine model, tx scoreboard and timing checks.
module tb_matrix_uart_seq;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb [$];
  logic       stall_q    = 1'b0;
  logic [7:0] stall_data = 8'h00;

  matrix_uart_seq_if #(.N_ELEM(N)) bus ();

  matrix_uart_seq #(.N_ELEM(N), .TIMEOUT(TMO)) dut (
    .clock(clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] ops);
    for (int i = 0; i < N; i++) send_byte(ops[8*i +: 8]);
  endtask

  // Engine model answer: pulse done and queue the expected tx bytes, r0 low byte first.
  task automatic eng_return(input logic [63:0] res);
    bus.eng_done   = 1'b1;
    bus.eng_result = res;
    for (int i = 0; i < 2 * N; i++) sb.push_back(res[8*i +: 8]);
    tick();
    bus.eng_done = 1'b0;
  endtask

  task automatic run_tx(input bit toggle, output int cycles);
    cycles = 0;
    for (int k = 0; k < 200 && bus.busy; k++) begin
      bus.tx_ready = toggle ? (((k / 3) % 2) == 1) : 1'b1;
      tick();
      cycles++;
    end
    bus.tx_ready = 1'b1;
    chk("tx_finish_busy", 64'(bus.busy), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_valid"}, 64'(bus.tx_valid), 64'd0);
    chk({tag, "_tx_data"}, 64'(bus.tx_data), 64'd0);
    chk({tag, "_eng_start"}, 64'(bus.eng_start), 64'd0);
    chk({tag, "_eng_op"}, 64'(bus.eng_op), 64'd0);
    chk({tag, "_gpio"}, 64'(bus.gpio_result), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_err_overrun"}, 64'(bus.err_overrun), 64'd0);
    chk({tag, "_err_timeout"}, 64'(bus.err_timeout), 64'd0);
  endtask

  // tx monitor: scoreboard pop on every accept, stability check while stalled
  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", 64'(bus.tx_valid), 64'd1);
        chk("stall_data", 64'(bus.tx_data), 64'(stall_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        chk("tx_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) chk("tx_byte", 64'(bus.tx_data), 64'(sb.pop_front()));
      end
      stall_q    = bus.tx_valid && !bus.tx_ready;
      stall_data = bus.tx_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cyc;
    logic any_tx;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'h00;
    bus.tx_ready   = 1'b1;
    bus.eng_done   = 1'b0;
    bus.eng_result = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;

    // 1: basic frame
    send_frame(32'h04030201);
    chk("t1_start", 64'(bus.eng_start), 64'd1);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    chk("t1_eng_op", 64'(bus.eng_op), 64'h04030201);
    tick();
    chk("t1_start_pulse", 64'(bus.eng_start), 64'd0);
    tick();
    eng_return(64'h0005_0005_0005_0005);
    chk("t1_gpio", 64'(bus.gpio_result), 64'h00050005);
    chk("t1_tx_valid", 64'(bus.tx_valid), 64'd1);
    run_tx(1'b0, cyc);
    chk("t1_tx_cycles", 64'(cyc), 64'(2 * N));
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // 2: tx backpressure
    send_frame(32'h24232221);
    tick();
    tick();
    eng_return({4{16'h1234}});
    chk("t2_gpio", 64'(bus.gpio_result), 64'h12341234);
    run_tx(1'b1, cyc);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // 3: engine timeout, then a normal frame
    send_frame(32'h40302010);
    chk("t3_start", 64'(bus.eng_start), 64'd1);
    any_tx = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      tick();
      if (bus.tx_valid) any_tx = 1'b1;
    end
    chk("t3_tmo_early", 64'(bus.err_timeout), 64'd0);
    chk("t3_busy_wait", 64'(bus.busy), 64'd1);
    tick();
    chk("t3_tmo_set", 64'(bus.err_timeout), 64'd1);
    chk("t3_collect", 64'(bus.busy), 64'd0);
    chk("t3_no_tx", 64'(any_tx || bus.tx_valid), 64'd0);
    send_frame(32'h44332211);
    chk("t3_start2", 64'(bus.eng_start), 64'd1);
    chk("t3_eng_op2", 64'(bus.eng_op), 64'h44332211);
    tick();
    tick();
    eng_return(64'h0004_0003_0002_0001);
    chk("t3_gpio", 64'(bus.gpio_result), 64'h00020001);
    run_tx(1'b0, cyc);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);
    chk("t3_tmo_sticky", 64'(bus.err_timeout), 64'd1);

    // 4: overrun during WAIT
    chk("t4_ovr_before", 64'(bus.err_overrun), 64'd0);
    send_frame(32'hA4A3A2A1);
    tick();
    send_byte(8'hAA);
    chk("t4_ovr_set", 64'(bus.err_overrun), 64'd1);
    eng_return(64'hBEEF_CAFE_0102_F00D);
    chk("t4_gpio", 64'(bus.gpio_result), 64'h0102F00D);
    run_tx(1'b0, cyc);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);
    send_frame(32'h08070605);
    chk("t4_eng_op_next", 64'(bus.eng_op), 64'h08070605);

    // 5: reset after three accepts, then a stray done
    tick();
    tick();
    eng_return(64'h0008_0007_0006_0005);
    repeat (3) tick();
    chk("t5_sb_left", 64'(sb.size()), 64'd5);
    reset        = 1'b1;
    bus.tx_ready = 1'b0;
    tick();
    chk_all_zero("t5");
    sb.delete();
    reset        = 1'b0;
    bus.tx_ready = 1'b1;
    bus.eng_done   = 1'b1;
    bus.eng_result = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.eng_done = 1'b0;
    chk("t5_stray_gpio", 64'(bus.gpio_result), 64'd0);
    chk("t5_stray_tx", 64'(bus.tx_valid), 64'd0);
    chk("t5_stray_busy", 64'(bus.busy), 64'd0);

    // 6: done in the cycle the counter reaches zero
    send_frame(32'h0C0B0A09);
    chk("t6_start", 64'(bus.eng_start), 64'd1);
    repeat (TMO) tick();
    chk("t6_still_wait", 64'(bus.busy), 64'd1);
    eng_return(64'h0D0C_0B0A_0908_0706);
    chk("t6_tmo_clear", 64'(bus.err_timeout), 64'd0);
    chk("t6_tx_valid", 64'(bus.tx_valid), 64'd1);
    chk("t6_gpio", 64'(bus.gpio_result), 64'h09080706);
    run_tx(1'b0, cyc);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);
    chk("t6_tmo_final", 64'(bus.err_timeout), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_uart_seq.md
# matrix_uart_seq

Sequencer between the UART byte interfaces of an IP slot and a 2x2 matrix compute engine. It collects `N_ELEM` operand bytes from the UART receiver and launches the engine with a start/done handshake. It then streams the 16-bit results back to the UART transmitter, least-significant byte first, and mirrors the first two results onto the GPIO result bus. It sits inside the selected IP wrapper, below the pad mux and beside the UART.

## Interface
Parameters:
- `N_ELEM`, 4: number of 8-bit operands per frame, which is also the number of 16-bit results.
- `TIMEOUT`, 1024: maximum cycles to wait for `eng_done` after `eng_start`. Must be ≥ 2.

Ports:
- `clock` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high.
- `rx_valid` in 1: single-cycle pulse, a received byte is on `rx_data`.
- `rx_data` in 8: received byte.
- `tx_valid` out 1: a byte is offered to the UART transmitter.
- `tx_data` out 8: byte offered for transmission.
- `tx_ready` in 1: transmitter accepts the byte when `tx_valid && tx_ready`.
- `eng_start` out 1: one-cycle pulse that launches the engine.
- `eng_op` out 8·N_ELEM: operands. Element i is at `[8i+7:8i]`. Held stable from `eng_start` until `eng_done` or timeout.
- `eng_done` in 1: single-cycle pulse, `eng_result` is valid in this cycle.
- `eng_result` in 16·N_ELEM: results. Element i is at `[16i+15:16i]`.
- `gpio_result` out 32: `{result[1], result[0]}` of the last completed frame.
- `busy` out 1: high in every state except COLLECT.
- `err_overrun` out 1: sticky flag.
- `err_timeout` out 1: sticky flag.

## Operation
States: COLLECT, START, WAIT, SEND.

- **COLLECT**
  - Each `rx_valid` stores `rx_data` into `op[idx]` and increments `idx`.
  - When the byte at index `N_ELEM-1` is stored, go to START. `idx` returns to 0.
- **START**
  - Assert `eng_start` for exactly one cycle, then go to WAIT.
  - Load the timeout counter with `TIMEOUT-1`.
- **WAIT**
  - The counter decrements every cycle.
  - On `eng_done`: latch all of `eng_result` into the result buffer, update `gpio_result`, clear the byte pointer, go to SEND.
  - Counter at 0 without `eng_done`: set `err_timeout`, go to COLLECT, and transmit nothing.
  - `eng_done` in the same cycle the counter reaches 0: the done wins.
- **SEND**
  - Serialise 2·N_ELEM bytes in this order: r0[7:0], r0[15:8], r1[7:0], and so on.
  - `tx_valid` stays high and `tx_data` stays stable until `tx_ready`. There is no combinational path from `tx_ready` to `tx_valid`.
  - After the last byte is accepted, go to COLLECT.
- **Overrun.** `rx_valid` in any state other than COLLECT drops the byte and sets `err_overrun`. The frame in progress is unaffected.
- **Sticky flags.** `err_overrun` and `err_timeout` clear only on `reset`.
- **Stray done.** `eng_done` outside WAIT is ignored.
- **Arithmetic.** The byte index and timeout counter are unsigned, sized with `$clog2`. No wrap is possible: the index resets on the transition to START.

## Timing
- **Reset values.** Every output is 0 on reset: `tx_valid`, `tx_data`, `eng_start`, `eng_op`, `gpio_result`, `busy`, both error flags. The state is COLLECT and `idx` is 0.
- **Reset mid-operation.**
  - Next cycle: all outputs are 0 and any partial frame or pending TX is discarded.
  - The engine is not notified. A late `eng_done` is ignored.
- **Start latency.** The last `rx_valid` is cycle N. `eng_start` is high in cycle N+1. `busy` is high from cycle N+1.
- **Done-to-TX latency.** `eng_done` is cycle D. `gpio_result` updates and `tx_valid` is first high in cycle D+1.
- **TX throughput.** With `tx_ready` tied high: one byte per cycle, 2·N_ELEM cycles, and COLLECT is re-entered the cycle after the last accept.
- **Timeout.** With no `eng_done`:
  - WAIT lasts exactly `TIMEOUT` cycles, with `eng_start` in cycle S.
  - `err_timeout` is high from cycle S+TIMEOUT+1.
  - COLLECT is re-entered in that same cycle.
- **Back-to-back frames.** A byte arriving in the same cycle as the final `tx_ready` accept counts as overrun. Bytes are accepted from the next cycle.

## Structure
- Package `matrix_seq_pkg`:
  - state enum `seq_state_e` with COLLECT, START, WAIT, SEND;
  - `BYTE_W` = 8;
  - `RES_W` = 16;
  - a helper function for the result-byte index.
- Sub-module `result_tx_serializer`:
  - owns the result buffer, byte pointer and valid/ready output register;
  - inputs are `load` and `results`; output is `last_accepted`.
- The top level holds the FSM, operand registers, timeout counter and flags.

## Test plan
1. **Basic frame.** Send bytes 01 02 03 04. The engine model returns 5,5,5,5 two cycles after start.
   - `eng_op`=0x04030201.
   - TX bytes 05 00 05 00 05 00 05 00.
   - `gpio_result`=0x00050005.
   - `busy` low afterwards.
2. **TX backpressure.** `tx_ready` toggles every 3 cycles; the engine returns 0x1234 for each result.
   - `tx_data` is stable while stalled.
   - Sequence is 34 12 repeated ×4, with no byte duplicated or lost.
3. **Engine timeout.** The engine never answers.
   - `err_timeout` rises exactly TIMEOUT+1 cycles after `eng_start`.
   - No `tx_valid`.
   - The next frame of 4 bytes completes normally.
4. **Overrun.** Inject 0xAA during WAIT.
   - `err_overrun`=1.
   - Results are transmitted unchanged.
   - The next frame's `eng_op` does not contain 0xAA.
5. **Reset mid-SEND.** Assert `reset` after 3 TX accepts.
   - All outputs are 0 the next cycle.
   - The state is COLLECT.
   - A stray `eng_done` is ignored.
6. **Done on the timeout edge.** `eng_done` arrives in the cycle the counter reaches 0.
   - Results are sent.
   - `err_timeout` stays 0.
